// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and constants for the 2x2 pooling stage
package pool_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // 18-bit working value: wide enough for the sum of four 16-bit pixels
    typedef logic signed [17:0] w18_t;

    function automatic w18_t max2(input w18_t a, input w18_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// rtl/pool_linebuf.sv - half-row buffer holding the even-row pair results
module pool_linebuf
    import pool_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [17:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [17:0]   rdata
);

    w18_t mem_q [DEPTH];
    w18_t mem_d [DEPTH];

    // next-state of the array: single write port
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // storage, cleared by the active-high synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pool2x2.sv
// rtl/pool2x2.sv - streaming 2x2 stride-2 max/average pooling stage
module pool2x2
    import pool_pkg::*;
#(
    parameter int MAX_N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic [3:0]  image_size,
    input  logic        pool_mode,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last
);

    localparam int DEPTH = MAX_N / 2;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t      state_q, state_d;
    logic [3:0]  n_q, n_d;
    logic        mode_q, mode_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    w18_t        h_q, h_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;

    logic [3:0]    n_eff, n_even, row_eff, col_eff;
    logic          mode_eff, in_win;
    w18_t          pix, pair, sum3, avg, res;
    logic          lb_we;
    logic [IW-1:0] lb_idx;
    logic [17:0]   lb_rdata_raw;
    w18_t          lb_rdata;

    assign lb_rdata = lb_rdata_raw;

    pool_linebuf #(.DEPTH(DEPTH), .IW(IW)) u_linebuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lb_we),
        .waddr (lb_idx),
        .wdata (pair),
        .raddr (lb_idx),
        .rdata (lb_rdata_raw)
    );

    // position tracking, pooling arithmetic and next-state selection
    always_comb begin
        // in IDLE the arriving pixel is (0,0) of a new frame with live settings
        n_eff    = (state_q == IDLE) ? image_size : n_q;
        mode_eff = (state_q == IDLE) ? pool_mode  : mode_q;
        row_eff  = (state_q == IDLE) ? 4'd0       : row_q;
        col_eff  = (state_q == IDLE) ? 4'd0       : col_q;
        n_even   = {n_eff[3:1], 1'b0};
        in_win   = (row_eff < n_even) && (col_eff < n_even);
        lb_idx   = col_eff[IW:1];

        pix  = {{2{in_data[15]}}, in_data};
        pair = (mode_eff == MODE_AVG) ? (h_q + pix) : max2(h_q, pix);
        sum3 = lb_rdata + h_q + pix;
        avg  = sum3 >>> 2;
        res  = (mode_eff == MODE_AVG) ? avg : max2(max2(lb_rdata, h_q), pix);

        state_d     = state_q;
        n_d         = n_q;
        mode_d      = mode_q;
        row_d       = row_q;
        col_d       = col_q;
        h_d         = h_q;
        lb_we       = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;

        if (in_valid) begin
            if (in_win) begin
                unique case ({row_eff[0], col_eff[0]})
                    2'b00, 2'b10: h_d = pix;
                    2'b01:        lb_we = 1'b1;
                    default: begin
                        out_valid_d = 1'b1;
                        out_data_d  = res[15:0];
                        out_last_d  = (row_eff == n_even - 4'd1) &&
                                      (col_eff == n_even - 4'd1);
                    end
                endcase
            end

            if (state_q == IDLE) begin
                n_d    = image_size;
                mode_d = pool_mode;
                row_d  = 4'd0;
                // a 1x1 frame is complete with its only pixel
                if (image_size > 4'd1) begin
                    state_d = RUN;
                    col_d   = 4'd1;
                end else begin
                    col_d   = 4'd0;
                end
            end else if (col_q == n_q - 4'd1) begin
                col_d = 4'd0;
                if (row_q == n_q - 4'd1) begin
                    state_d = IDLE;
                    row_d   = 4'd0;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    // FSM, counters, hold register and registered outputs
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            mode_q      <= MODE_MAX;
            row_q       <= '0;
            col_q       <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule
